// File: rtl/mul32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mul32_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEGA,
    NEGB,
    MUL,
    NEGLO,
    NEGHI,
    DONE
  } state_t;

endpackage

// File: rtl/add32_112.sv
// Plain 32-bit ripple adder shared by the multiplier sequence.
module add32_112 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c0,
  output logic [31:0] s,
  output logic        c32
);

  logic [32:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {32'b0, c0};
  assign s     = w_sum[31:0];
  assign c32   = w_sum[32];

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Shift-and-add 32x32->64 multiplier time-sharing one 32-bit adder,
// with adder-based operand/result negation for signed mode.
module mul32_seq_ctrl
  import mul32_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1,
  parameter int ITER      = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_zero,
  output logic             prod_ovf,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_phi;
  logic             r_sgn;
  logic             r_neg;
  logic             r_cy;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_c0;
  logic [WIDTH-1:0] w_s;
  logic             w_c32;
  logic [WIDTH-1:0] w_phi_n;
  logic [WIDTH-1:0] w_q_n;
  logic             w_sgn;
  logic             w_last;
  logic             w_enter_done;

  add32_112 u_add (
    .a   (w_add_a),
    .b   (w_add_b),
    .c0  (w_c0),
    .s   (w_s),
    .c32 (w_c32)
  );

  assign w_sgn  = sign_mode & SIGNED_EN;
  assign w_last = (r_cnt == CNT_W'(ITER - 1));
  assign w_enter_done = (r_state == NEGHI) ||
                        (r_state == MUL && w_last && !r_sgn);

  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    w_c0    = 1'b0;
    unique case (r_state)
      NEGA: begin
        w_add_a = ~r_m;
        w_c0    = 1'b1;
      end
      NEGB, NEGLO: begin
        w_add_a = ~r_q;
        w_c0    = 1'b1;
      end
      MUL: begin
        w_add_a = r_phi;
        w_add_b = r_q[0] ? r_m : '0;
      end
      NEGHI: begin
        w_add_a = ~r_phi;
        w_c0    = r_cy;
      end
      default: ;
    endcase
  end

  // Next {P_hi,Q} for the two states that can hand over to DONE
  always_comb begin
    w_phi_n = r_phi;
    w_q_n   = r_q;
    if (r_state == MUL) begin
      w_phi_n = {w_c32, w_s[WIDTH-1:1]};
      w_q_n   = {w_s[0], r_q[WIDTH-1:1]};
    end else if (r_state == NEGHI && r_neg) begin
      w_phi_n = w_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_q         <= '0;
      r_phi       <= '0;
      r_sgn       <= 1'b0;
      r_neg       <= 1'b0;
      r_cy        <= 1'b0;
      r_cnt       <= '0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      prod_hi     <= '0;
      prod_lo     <= '0;
      prod_zero   <= 1'b0;
      prod_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_m         <= a;
            r_q         <= b;
            r_sgn       <= w_sgn;
            r_neg       <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_phi       <= '0;
            r_cnt       <= '0;
            r_cy        <= 1'b0;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            r_state     <= w_sgn ? NEGA : MUL;
          end
        end
        NEGA: begin
          if (r_m[WIDTH-1]) r_m <= w_s;
          r_state <= NEGB;
        end
        NEGB: begin
          if (r_q[WIDTH-1]) r_q <= w_s;
          r_state <= MUL;
        end
        MUL: begin
          r_phi <= w_phi_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= r_sgn ? NEGLO : DONE;
        end
        NEGLO: begin
          if (r_neg) begin
            r_q  <= w_s;
            r_cy <= w_c32;
          end else begin
            r_cy <= 1'b0;
          end
          r_state <= NEGHI;
        end
        NEGHI: begin
          r_phi   <= w_phi_n;
          r_state <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            prod_hi     <= '0;
            prod_lo     <= '0;
            prod_zero   <= 1'b0;
            prod_ovf    <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Result and flags are captured from the final datapath values
      if (w_enter_done) begin
        res_valid <= 1'b1;
        prod_hi   <= w_phi_n;
        prod_lo   <= w_q_n;
        prod_zero <= ({w_phi_n, w_q_n} == '0);
        prod_ovf  <= r_sgn ? (w_phi_n != {WIDTH{w_q_n[WIDTH-1]}})
                           : (w_phi_n != '0);
      end
    end
  end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Randomised bench for mul32_seq_ctrl against an arithmetic product model.
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sign_mode = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        prod_zero;
  logic        prod_ovf;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [63:0] m_prod = '0;
  bit          m_ovf = 1'b0;

  mul32_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sign_mode   (sign_mode),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .prod_hi     (prod_hi),
    .prod_lo     (prod_lo),
    .prod_zero   (prod_zero),
    .prod_ovf    (prod_ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input bit s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  function automatic bit model_ovf(input logic [63:0] p, input bit s);
    longint sp;
    sp = longint'(p);
    if (s) return (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    return p > 64'h0000_0000_FFFF_FFFF;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      if (m_busy) m_cnt++;
      ev = m_busy && (m_cnt >= m_lat);
      chk("res_valid", {63'b0, res_valid}, {63'b0, ev});
      chk("busy", {63'b0, busy}, {63'b0, m_busy});
      chk("start_ready", {63'b0, start_ready}, {63'b0, !m_busy});
      if (ev) begin
        chk("prod", {prod_hi, prod_lo}, m_prod);
        chk("zero", {63'b0, prod_zero}, {63'b0, m_prod == 64'b0});
        chk("ovf", {63'b0, prod_ovf}, {63'b0, m_ovf});
      end
    end
  end

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb,
                       input bit ts, input int hold, input bit pulse,
                       input bit pin, input logic [63:0] ep,
                       input bit eovf);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    sign_mode = ts;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sign_mode = 1'($urandom);
    m_prod = model_prod(ta, tb, ts);
    m_ovf = model_ovf(m_prod, ts);
    m_lat = ts ? 37 : 33;
    m_cnt = 0;
    m_busy = 1'b1;
    if (pin) begin
      chk("model_prod", m_prod, ep);
      chk("model_ovf", {63'b0, m_ovf}, {63'b0, eovf});
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start_valid = pulse && (n == 12 || n == 13);
    end while (!res_valid && n < 60);
    start_valid = 1'b0;
    chk("latency", 64'(n), 64'(m_lat));
    if (pin) chk("pinned_prod", {prod_hi, prod_lo}, ep);
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (pin) chk("held_prod", {prod_hi, prod_lo}, ep);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    m_busy = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #12;
    chk("rst_start_ready", {63'b0, start_ready}, 64'd1);
    chk("rst_outs", {res_valid, busy, prod_zero, prod_ovf, prod_hi, prod_lo},
        '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h4000_0000, 32'h4, 0, 0, 0, 1, 64'h1_0000_0000, 1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1,
          64'hFFFF_FFFE_0000_0001, 1);
    do_op(32'h0, 32'h1234_5678, 0, 0, 0, 1, 64'h0, 0);
    do_op(32'hFFFF_FFFD, 32'h7, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 1, 64'h1, 0);
    do_op(32'h8000_0000, 32'h8000_0000, 1, 0, 0, 1,
          64'h4000_0000_0000_0000, 1);
    do_op(32'h8000_0000, 32'h1, 1, 0, 0, 1, 64'hFFFF_FFFF_8000_0000, 0);
    do_op(32'h0000_1234, 32'h0000_5678, 0, 5, 1, 1, 64'h0626_0060, 0);

    // abort in the middle of the multiply sequence
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    sign_mode = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    m_prod = model_prod(32'h1234_5678, 32'h9ABC_DEF0, 0);
    m_ovf = 1'b1;
    m_lat = 33;
    m_cnt = 0;
    m_busy = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_busy = 1'b0;
    #1;
    chk("abort_start_ready", {63'b0, start_ready}, 64'd1);
    chk("abort_outs",
        {res_valid, busy, prod_zero, prod_ovf, prod_hi, prod_lo}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd6, 32'd7, 0, 0, 0, 1, 64'd42, 0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra, rb;
      ra = pick();
      rb = pick();
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 3),
            1'($urandom), 0, 64'h0, 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
